halut_encoder_ctrl: RTL

Controller for the HALUT encoder array.
- Config phase: accepts one global threshold-write stream with valid/ready and demuxes it onto the per-unit threshold write ports.
- Run phase: drives the encoder enable for a programmed number of input rows, then counts and checks the array's (c_addr, k_addr, valid) output stream.
- Gates and forwards that stream to the decoder with a row index, and signals done/error.

---
 rtl/halut_ctrl_pkg.sv | 34 +++
 rtl/halut_thresh_demux.sv | 52 +++++
 rtl/halut_encoder_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/halut_ctrl_pkg.sv
// Shared types and helpers for the HALUT encoder controller.
// Contents:
//   - state_t: controller FSM state (IDLE/RUN/DONE).
//   - width helpers: codebook-address width and per-unit threshold-memory
//     address width.
//   - addr_unit/addr_local: split a global threshold address (c*K + k) into
//     the owning encoder unit and the address inside that unit's memory.
package halut_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int caddr_width(input int c);
    return (c > 1) ? $clog2(c) : 1;
  endfunction

  function automatic int thresh_addr_width(input int c, input int k, input int units);
    return $clog2((c / units) * k);
  endfunction

  // Codebooks are striped round-robin across units: unit = c % EncUnits.
  function automatic int addr_unit(input int addr, input int k, input int units);
    return (addr / k) % units;
  endfunction

  // Within a unit, its codebooks are packed densely: (c / EncUnits) * K + k.
  function automatic int addr_local(input int addr, input int k, input int units);
    return ((addr / k) / units) * k + (addr % k);
  endfunction

endpackage

// File: rtl/halut_thresh_demux.sv
// Registered threshold-write demux.
// One accepted global write (wr) lands one cycle later on exactly one unit:
// that unit's we pulses for a cycle and its waddr/wdata take the new values;
// every other unit keeps its previous waddr/wdata.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   wr               accepted write strobe
//   addr, data       global address (c*K + k) and threshold value
//   waddr, wdata, we per-unit write port
module halut_thresh_demux
  import halut_ctrl_pkg::*;
#(
  parameter  int K                  = 16,
  parameter  int C                  = 32,
  parameter  int DataTypeWidth      = 16,
  parameter  int EncUnits           = 4,
  localparam int TotalAddrWidth     = $clog2(C * K),
  localparam int ThreshMemAddrWidth = thresh_addr_width(C, K, EncUnits)
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         wr,
  input  logic [TotalAddrWidth-1:0]                    addr,
  input  logic [DataTypeWidth-1:0]                     data,
  output logic [EncUnits-1:0][ThreshMemAddrWidth-1:0]  waddr,
  output logic [EncUnits-1:0][DataTypeWidth-1:0]       wdata,
  output logic [EncUnits-1:0]                          we
);

  logic [31:0]                   unit_sel;
  logic [ThreshMemAddrWidth-1:0] laddr;

  assign unit_sel = 32'(addr_unit(32'(addr), K, EncUnits));
  assign laddr    = ThreshMemAddrWidth'(addr_local(32'(addr), K, EncUnits));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr <= '0;
      wdata <= '0;
      we    <= '0;
    end else begin
      for (int u = 0; u < EncUnits; u++) begin
        we[u] <= wr && (unit_sel == u);
        if (wr && (unit_sel == u)) begin
          waddr[u] <= laddr;
          wdata[u] <= data;
        end
      end
    end
  end

endmodule

// File: rtl/halut_encoder_ctrl.sv
// HALUT encoder array controller.
// IDLE: accepts threshold writes (cfg_valid_i/cfg_ready_o) and demuxes them
//   onto the per-unit write ports; start_i launches a run of rows_i rows.
// RUN: holds encoder_o high, forwards the array's (c, k, valid) stream with a
//   row index, flags out-of-order codebooks in sticky err_o, and finishes on
//   the last codebook of the last row (or aborts on abort_i).
// DONE: one-cycle done_o, then back to IDLE.
// Optional: define HALUT_ENCODER_CTRL_TIMEOUT_EN to add a RUN watchdog that
//   sets err_o and returns to IDLE after TimeoutCycles cycles with no
//   enc_valid_i. Without it, RUN waits indefinitely.
// Ports: clk_i/rst_i; cfg_* write stream; waddr_o/wdata_o/we_o per-unit
//   threshold ports; start_i/rows_i/abort_i run control; encoder_o enable;
//   enc_* array stream in; out_* forwarded stream; busy_o/done_o/err_o status.
module halut_encoder_ctrl
  import halut_ctrl_pkg::*;
#(
  parameter  int K                  = 16,
  parameter  int C                  = 32,
  parameter  int DataTypeWidth      = 16,
  parameter  int EncUnits           = 4,
  parameter  int RowWidth           = 16,
  parameter  int TimeoutCycles      = 64,
  localparam int CAddrWidth         = caddr_width(C),
  localparam int TreeDepth          = $clog2(K),
  localparam int TotalAddrWidth     = $clog2(C * K),
  localparam int ThreshMemAddrWidth = thresh_addr_width(C, K, EncUnits)
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         cfg_valid_i,
  output logic                                         cfg_ready_o,
  input  logic [TotalAddrWidth-1:0]                    cfg_addr_i,
  input  logic [DataTypeWidth-1:0]                     cfg_data_i,
  output logic [EncUnits-1:0][ThreshMemAddrWidth-1:0]  waddr_o,
  output logic [EncUnits-1:0][DataTypeWidth-1:0]       wdata_o,
  output logic [EncUnits-1:0]                          we_o,
  input  logic                                         start_i,
  input  logic [RowWidth-1:0]                          rows_i,
  input  logic                                         abort_i,
  output logic                                         encoder_o,
  input  logic [CAddrWidth-1:0]                        enc_c_addr_i,
  input  logic [TreeDepth-1:0]                         enc_k_addr_i,
  input  logic                                         enc_valid_i,
  output logic [CAddrWidth-1:0]                        out_c_addr_o,
  output logic [TreeDepth-1:0]                         out_k_addr_o,
  output logic [RowWidth-1:0]                          out_row_o,
  output logic                                         out_valid_o,
  output logic                                         busy_o,
  output logic                                         done_o,
  output logic                                         err_o
);

  if ((C % EncUnits) != 0 || (EncUnits & (EncUnits - 1)) != 0 || TimeoutCycles < 1) begin : g_bad_param
    $error("halut_encoder_ctrl: EncUnits must be a power of two dividing C; TimeoutCycles >= 1");
  end

  state_t                state, state_next;
  logic [CAddrWidth-1:0] c_cnt;
  logic [RowWidth-1:0]   row_cnt, rows_q;
  logic                  start_acc, fwd, last_c, final_out, timeout;

  assign start_acc = (state == IDLE) && start_i;
  assign fwd       = (state == RUN) && enc_valid_i;
  assign last_c    = (c_cnt == CAddrWidth'(C - 1));
  assign final_out = fwd && last_c && (row_cnt == rows_q - RowWidth'(1));

`ifdef HALUT_ENCODER_CTRL_TIMEOUT_EN
  localparam int WdWidth = $clog2(TimeoutCycles + 1);
  logic [WdWidth-1:0] wdog;

  // Counts consecutive RUN cycles without an array output; fires on the
  // TimeoutCycles-th such cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                             wdog <= '0;
    else if (state != RUN || enc_valid_i)  wdog <= '0;
    else                                   wdog <= wdog + WdWidth'(1);
  end

  assign timeout = (state == RUN) && !enc_valid_i && (wdog == WdWidth'(TimeoutCycles - 1));
`else
  assign timeout = 1'b0;
`endif

  halut_thresh_demux #(
    .K(K), .C(C), .DataTypeWidth(DataTypeWidth), .EncUnits(EncUnits)
  ) u_demux (
    .clk  (clk_i),
    .rst  (rst_i),
    .wr   (cfg_valid_i && cfg_ready_o),
    .addr (cfg_addr_i),
    .data (cfg_data_i),
    .waddr(waddr_o),
    .wdata(wdata_o),
    .we   (we_o)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Next state; abort outranks both the final output and the watchdog.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_i) state_next = (rows_i != '0) ? RUN : DONE;
      RUN:     if (abort_i || timeout) state_next = IDLE;
               else if (final_out)     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    cfg_ready_o  = (state == IDLE);
    busy_o       = (state != IDLE);
    done_o       = (state == DONE);
    out_valid_o  = fwd;
    out_c_addr_o = fwd ? enc_c_addr_i : '0;
    out_k_addr_o = fwd ? enc_k_addr_i : '0;
    out_row_o    = fwd ? row_cnt : '0;
  end

  // Registered so it follows RUN exactly: high from the first RUN cycle,
  // low the cycle after RUN is left.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) encoder_o <= 1'b0;
    else       encoder_o <= (state_next == RUN);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      c_cnt   <= '0;
      row_cnt <= '0;
      rows_q  <= '0;
      err_o   <= 1'b0;
    end else if (start_acc) begin
      c_cnt   <= '0;
      row_cnt <= '0;
      rows_q  <= rows_i;
      err_o   <= 1'b0;
    end else begin
      if (timeout) err_o <= 1'b1;
      if (fwd) begin
        if (enc_c_addr_i != c_cnt) err_o <= 1'b1;
        c_cnt <= last_c ? '0 : c_cnt + CAddrWidth'(1);
        if (last_c) row_cnt <= row_cnt + RowWidth'(1);
      end
    end
  end

endmodule
